// File: rtl/comb_share_arbiter.sv
// comb_share_arbiter
// Round-robin arbiter that time-shares one single-cycle combinational
// resource among N requesters. The granted requester's operand is muxed
// onto `a`, and the resource's answer `b` is registered on `dout` together
// with the index of the requester that produced it.

module comb_share_arbiter #(
    parameter int N        = 4,
    parameter int W        = 1,
    parameter int MAX_HOLD = 4,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  din,
    output logic [N-1:0]    gnt,
    output logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    dout,
    output logic            dout_valid,
    output logic [IW-1:0]   dout_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    logic [IW-1:0]  last;
    logic [HW-1:0]  hold;

    logic [IW-1:0]  holder;
    logic [IW-1:0]  sel_base;
    logic           sel_found;
    logic [IW-1:0]  sel_idx;
    logic [N-1:0]   sel_onehot;
    logic           hold_last;
    logic           holder_req;
    logic           release_now;

    // Encode the one-hot grant into the index of the current holder.
    always_comb begin
        holder = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                holder = IW'(i);
            end
        end
    end

    // Round-robin search: first requesting index after the base, wrapping
    // modulo N, so the base itself (the former holder) is tried last.
    // While granting, the base is the holder because a release makes it
    // the new `last` on the same edge.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        sel_base   = (state == GRANT) ? holder : last;
        for (int k = N; k >= 1; k--) begin
            cand     = (int'(sel_base) + k) % N;
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        if (sel_found) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

    // Release happens when the holder drops its request or uses its last
    // allowed consecutive cycle.
    always_comb begin
        holder_req  = req[holder];
        hold_last   = (hold == HW'(MAX_HOLD - 1));
        release_now = !holder_req || hold_last;
    end

    // Operand mux: only the granted requester's slice reaches the resource;
    // the all-zero grant of IDLE drives zero.
    always_comb begin
        a = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                a = din[i*W +: W];
            end
        end
    end

    // Arbitration FSM with registered grant and captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            last       <= IW'(N - 1);
            hold       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    if (sel_found) begin
                        gnt   <= sel_onehot;
                        hold  <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (holder_req) begin
                        dout       <= b;
                        dout_id    <= holder;
                        dout_valid <= 1'b1;
                    end else begin
                        dout_valid <= 1'b0;
                    end
                    if (release_now) begin
                        last <= holder;
                        hold <= '0;
                        if (sel_found) begin
                            gnt <= sel_onehot;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    gnt        <= '0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comb_share_arbiter.sv
// Testbench for comb_share_arbiter: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the arbitration rules.

module tb_comb_share_arbiter;

    localparam int N        = 4;
    localparam int W        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  din;
    logic [N-1:0]    gnt;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic [IW-1:0]   dout_id;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state: holder index (-1 when idle), consecutive
    // cycles already served, last released holder and captured result.
    int              m_holder;
    int              m_hold;
    int              m_last;
    logic [W-1:0]    m_dout;
    logic            m_valid;
    int              m_id;

    comb_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .a          (a),
        .b          (b),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_id    (dout_id)
    );

    // Shared resource is the identity function.
    assign b = a;

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [W-1:0] slice(input logic [N*W-1:0] d, input int i);
        return d[i*W +: W];
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int base);
        for (int k = 1; k <= N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] e;
        e = '0;
        if (m_holder >= 0) e[m_holder] = 1'b1;
        return e;
    endfunction

    function automatic logic [W-1:0] exp_a();
        if (m_holder < 0) return '0;
        return slice(din, m_holder);
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_hold   = 0;
        m_last   = N - 1;
        m_dout   = '0;
        m_valid  = 1'b0;
        m_id     = 0;
    endtask

    task automatic model_edge();
        int h;
        int p;
        if (m_holder < 0) begin
            m_valid = 1'b0;
            p = pick(req, m_last);
            if (p >= 0) begin
                m_holder = p;
                m_hold   = 0;
            end
        end else begin
            h = m_holder;
            if (req[h]) begin
                m_dout  = slice(din, h);
                m_id    = h;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (!req[h] || m_hold == MAX_HOLD - 1) begin
                m_last   = h;
                m_holder = pick(req, h);
                m_hold   = 0;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        din = '0;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        din = N*W'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt);
            end
            checks++;
            if (a !== 4'h0) begin
                fails++;
                $display("[TB] FAIL reset_a: got %h expected 0", a);
            end
            checks++;
            if (dout_valid !== 1'b0 || dout_id !== 2'd0) begin
                fails++;
                $display("[TB] FAIL reset_dout: got valid=%b id=%0d expected valid=0 id=0", dout_valid, dout_id);
            end
        end
        rst = 1'b0;
        model_reset();
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL reset_first_grant: got %b expected 0001", gnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        din = 16'h0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || a !== 4'h1) begin
            fails++;
            $display("[TB] FAIL single_grant: got gnt=%b a=%h expected gnt=0100 a=1", gnt, a);
        end
        step();
        checks++;
        if (dout !== 4'h1 || dout_id !== 2'd2 || dout_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_capture: got dout=%h id=%0d valid=%b expected dout=1 id=2 valid=1",
                     dout, dout_id, dout_valid);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || dout_valid !== 1'b0 || a !== 4'h0) begin
            fails++;
            $display("[TB] FAIL single_drop: got gnt=%b valid=%b a=%h expected gnt=0000 valid=0 a=0",
                     gnt, dout_valid, a);
        end
    endtask

    task automatic test_round_robin();
        int seq[14] = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0, 0};
        logic [N-1:0] e;
        do_reset();
        req = 4'b1011;
        for (int i = 0; i < 14; i++) begin
            din = N*W'($urandom);
            step();
            e = '0;
            e[seq[i]] = 1'b1;
            checks++;
            if (gnt !== e) begin
                fails++;
                $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, e);
            end
            if (i > 0) begin
                checks++;
                if (dout_valid !== 1'b1 || int'(dout_id) != seq[i-1] || dout !== m_dout) begin
                    fails++;
                    $display("[TB] FAIL rr_dout[%0d]: got valid=%b id=%0d dout=%h expected valid=1 id=%0d dout=%h",
                             i, dout_valid, dout_id, dout, seq[i-1], m_dout);
                end
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0010;
        din = 16'h5A3C;
        step();
        step();
        checks++;
        if (gnt !== 4'b0010 || dout_valid !== 1'b1 || dout_id !== 2'd1) begin
            fails++;
            $display("[TB] FAIL early_setup: got gnt=%b valid=%b id=%0d expected gnt=0010 valid=1 id=1",
                     gnt, dout_valid, dout_id);
        end
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000 || dout_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL early_release: got gnt=%b valid=%b expected gnt=1000 valid=0", gnt, dout_valid);
        end
        step();
        checks++;
        if (dout_valid !== 1'b1 || dout_id !== 2'd3 || dout !== 4'h5) begin
            fails++;
            $display("[TB] FAIL early_next: got valid=%b id=%0d dout=%h expected valid=1 id=3 dout=5",
                     dout_valid, dout_id, dout);
        end
    endtask

    task automatic test_solo_wrap();
        logic [W-1:0] prev;
        do_reset();
        req  = 4'b1000;
        prev = '0;
        for (int i = 0; i < 13; i++) begin
            din  = N*W'($urandom);
            prev = slice(din, 3);
            step();
            checks++;
            if (gnt !== 4'b1000) begin
                fails++;
                $display("[TB] FAIL solo_gnt[%0d]: got %b expected 1000", i, gnt);
            end
            if (i > 0) begin
                checks++;
                if (dout_valid !== 1'b1 || dout_id !== 2'd3 || dout !== m_dout) begin
                    fails++;
                    $display("[TB] FAIL solo_dout[%0d]: got valid=%b id=%0d dout=%h expected valid=1 id=3 dout=%h",
                             i, dout_valid, dout_id, dout, m_dout);
                end
            end
        end
        checks++;
        if (dout !== prev && dout_valid === 1'b1) begin
            fails++;
            $display("[TB] FAIL solo_last_result: got %h expected %h", dout, prev);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        din = 16'h0900;
        step();
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL async_setup: got %b expected 0100", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || a !== 4'h0 || dout_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset: got gnt=%b a=%h valid=%b expected gnt=0000 a=0 valid=0",
                     gnt, a, dout_valid);
        end
        model_reset();
        #1;
        rst = 1'b0;
        req = 4'b0101;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL async_first_grant: got %b expected 0001", gnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            din = N*W'($urandom);
            step();
            checks++;
            if (gnt !== exp_gnt() || a !== exp_a() || dout_valid !== m_valid ||
                (m_valid && (dout !== m_dout || int'(dout_id) != m_id))) begin
                fails++;
                $display("[TB] FAIL random[%0d]: got gnt=%b a=%h valid=%b dout=%h id=%0d expected gnt=%b a=%h valid=%b dout=%h id=%0d",
                         i, gnt, a, dout_valid, dout, dout_id, exp_gnt(), exp_a(), m_valid, m_dout, m_id);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        din = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_solo_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
